// File: rtl/trips_types.sv
// Flit format and geometry constants shared between the memory-tile endpoint
// and the network packers.
package trips_types;

    localparam int FLIT_DATA_W = 64;
    localparam int WIDE_BEATS  = 4;
    localparam int ADDR_W      = 32;
    localparam int SRC_CORE_W  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic                   is_read;
        logic                   is_wide;
        logic [SRC_CORE_W-1:0]  src_core;
        logic [FLIT_DATA_W-1:0] data;
        logic                   last_flit;
        logic                   ipriority;
    } mem_flit_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WIDE = 2'd1,
        ST_RD_SEND = 2'd2
    } ep_state_t;

    // Responses never carry is_read; wide responses are issued at raised priority.
    function automatic mem_flit_t make_rsp(
        input logic [ADDR_W-1:0]      addr,
        input logic                   wide,
        input logic [SRC_CORE_W-1:0]  src_core,
        input logic [FLIT_DATA_W-1:0] data,
        input logic                   last_flit
    );
        mem_flit_t f;
        f.addr      = addr;
        f.is_read   = 1'b0;
        f.is_wide   = wide;
        f.src_core  = src_core;
        f.data      = data;
        f.last_flit = last_flit;
        f.ipriority = wide;
        return f;
    endfunction

endpackage

// File: rtl/tile_sram_bank.sv
// Single-write-port word SRAM for one memory tile; the read port is
// combinational so the endpoint can capture a word straight into its response register.
module tile_sram_bank
    import trips_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [FLIT_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [FLIT_DATA_W-1:0] rdata
);

    logic [FLIT_DATA_W-1:0] mem [DEPTH_WORDS];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_tile_endpoint.sv
// Memory-tile endpoint: turns request flits from the local router port into
// SRAM reads/writes and streams response flits back for reads.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; narrow writes complete here
// ST_WR_WIDE | absorbing beats 1..3 of a wide write into base+beat_cnt
// ST_RD_SEND | presenting response beat beat_cnt until the router acks it
module mem_tile_endpoint
    import trips_types::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 srf_en,
    input  logic                 rx_req,
    input  mem_flit_t            rx_flit,
    output logic                 rx_ack,
    output logic                 tx_req,
    output mem_flit_t            tx_flit,
    input  logic                 tx_ack,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] proto_err_cnt
);

    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int BEAT_W    = $clog2(WIDE_BEATS);
    localparam int ALIGN_LSB = 3 + BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WIDE_BEATS - 1);

    ep_state_t             state;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDX_W-1:0]      base_word;
    logic [ADDR_W-1:0]     base_addr;
    logic [SRC_CORE_W-1:0] src_q;
    logic                  wide_q;

    logic                   rx_fire;
    logic                   tx_fire;
    logic [IDX_W-1:0]       req_word;
    logic [IDX_W-1:0]       req_base;
    logic                   req_wide;
    logic [IDX_W-1:0]       req_target;
    logic [ADDR_W-1:0]      req_rsp_addr;
    logic [BEAT_W-1:0]      next_beat;
    logic                   rd_final;
    logic                   beat_err;
    logic                   err_inc;
    logic                   sram_we;
    logic [IDX_W-1:0]       sram_waddr;
    logic [IDX_W-1:0]       sram_raddr;
    logic [FLIT_DATA_W-1:0] sram_rdata;

    assign rx_ack = (state == ST_IDLE) || (state == ST_WR_WIDE);
    assign busy   = (state != ST_IDLE);

    assign rx_fire = rx_req && rx_ack;
    assign tx_fire = tx_req && tx_ack;

    // Byte address -> word index; low 3 bits and bits above the index wrap away.
    assign req_word     = rx_flit.addr[3 +: IDX_W];
    assign req_base     = {req_word[IDX_W-1:BEAT_W], BEAT_W'(0)};
    assign req_wide     = rx_flit.is_wide && srf_en;
    assign req_target   = req_wide ? req_base : req_word;
    assign req_rsp_addr = req_wide ? {rx_flit.addr[ADDR_W-1:ALIGN_LSB], ALIGN_LSB'(0)}
                                   : rx_flit.addr;

    assign next_beat = beat_cnt + 1'b1;
    assign rd_final  = !wide_q || (beat_cnt == LAST_BEAT);

    assign beat_err = (rx_flit.last_flit != (beat_cnt == LAST_BEAT))
                   || (rx_flit.src_core != src_q);

    always_comb begin
        err_inc = 1'b0;
        if (rx_fire) begin
            if (state == ST_IDLE) begin
                err_inc = !rx_flit.is_read && req_wide && rx_flit.last_flit;
            end else if (state == ST_WR_WIDE) begin
                err_inc = beat_err;
            end
        end
    end

    always_comb begin
        sram_we    = 1'b0;
        sram_waddr = req_target;
        if (state == ST_WR_WIDE) begin
            sram_we    = rx_fire;
            sram_waddr = base_word + IDX_W'(beat_cnt);
        end else if (state == ST_IDLE) begin
            sram_we    = rx_fire && !rx_flit.is_read;
        end
    end

    // In RD_SEND the read port looks one beat ahead so the next flit loads on ack.
    assign sram_raddr = (state == ST_RD_SEND) ? base_word + IDX_W'(next_beat) : req_target;

    tile_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .waddr (sram_waddr),
        .wdata (rx_flit.data),
        .raddr (sram_raddr),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_req        <= 1'b0;
            tx_flit       <= '0;
            beat_cnt      <= '0;
            base_word     <= '0;
            base_addr     <= '0;
            src_q         <= '0;
            wide_q        <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            if (err_inc && (proto_err_cnt != '1)) begin
                proto_err_cnt <= proto_err_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (rx_flit.is_read) begin
                            base_word <= req_target;
                            base_addr <= req_rsp_addr;
                            src_q     <= rx_flit.src_core;
                            wide_q    <= req_wide;
                            beat_cnt  <= '0;
                            tx_req    <= 1'b1;
                            tx_flit   <= make_rsp(req_rsp_addr, req_wide, rx_flit.src_core,
                                                  sram_rdata, !req_wide);
                            state     <= ST_RD_SEND;
                        end else if (req_wide) begin
                            base_word <= req_base;
                            src_q     <= rx_flit.src_core;
                            beat_cnt  <= BEAT_W'(1);
                            state     <= ST_WR_WIDE;
                        end
                    end
                end

                ST_WR_WIDE: begin
                    if (rx_fire) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= next_beat;
                        end
                    end
                end

                ST_RD_SEND: begin
                    if (tx_fire) begin
                        if (rd_final) begin
                            tx_req   <= 1'b0;
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= next_beat;
                            tx_flit  <= make_rsp(base_addr, wide_q, src_q, sram_rdata,
                                                 next_beat == LAST_BEAT);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic unused_rx_bits;
    assign unused_rx_bits = rx_flit.ipriority;

endmodule
